// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial-add sequencer.
//   state_t           : sequencer FSM state encoding (IDLE, ISSUE, RELEASE)
//   BIT_WIDTH_DEFAULT : default operand / sum width
package serial_add_pkg;

  localparam int BIT_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/sa_operand_fifo.sv
// Operand-pair queue for the serial-add sequencer.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   push, push_data     : write request / data (ignored when full)
//   pop, pop_data       : read request / head entry (ignored when empty)
//   full, empty         : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sa_operand_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Queues operand pairs and issues them one at a time to a serial adder
// using a start/done four-phase handshake, holding each result until the
// consumer takes it.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   in_valid, in_ready, in_a/b   : operand-pair input handshake
//   add_ain/bin, add_start       : operands and start request to the adder
//   add_sum, add_done            : result and done from the adder
//   out_valid, out_ready         : result handshake
//   out_sum, out_carry           : held result and unsigned carry-out
//   busy                         : FSM is not in IDLE
// Build option: define SERIAL_ADD_SEQ_CARRY_EN to compute out_carry;
// otherwise out_carry is tied low.
//
// state   | meaning
// IDLE    | waiting for a queued pair and a free result slot
// ISSUE   | add_start high, waiting for add_done
// RELEASE | add_start low, waiting for add_done to drop
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic [BIT_WIDTH-1:0] add_ain,
  output logic [BIT_WIDTH-1:0] add_bin,
  output logic                 add_start,
  input  logic [BIT_WIDTH-1:0] add_sum,
  input  logic                 add_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_sum,
  output logic                 out_carry,
  output logic                 busy
);

  state_t                   state;
  state_t                   state_next;
  logic [2*BIT_WIDTH-1:0]   head;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     capture;
  logic [BIT_WIDTH-1:0]     op_a;
  logic [BIT_WIDTH-1:0]     op_b;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign add_ain  = op_a;
  assign add_bin  = op_b;
  assign busy     = (state != IDLE);

  sa_operand_fifo #(
    .WIDTH (2*BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // add_done is only looked at in ISSUE/RELEASE, so a stale done in IDLE
  // has no effect.
  always_comb begin
    state_next = state;
    add_start  = 1'b0;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !out_valid) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        add_start = 1'b1;
        if (add_done) begin
          capture    = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!add_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture only happens in ISSUE, which is entered with out_valid low,
  // so capture and consumer-accept never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      if (pop) {op_a, op_b} <= head;
      if (capture) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_ADD_SEQ_CARRY_EN
  // Unsigned wrap of op_a + op_b shows up as a sum smaller than op_a.
  always_ff @(posedge clock) begin
    if (reset)        out_carry <= 1'b0;
    else if (capture) out_carry <= (add_sum < op_a);
  end
`else
  assign out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;

  localparam int W   = 8;
  localparam int LAT = 8;
`ifdef SERIAL_ADD_SEQ_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] add_ain, add_bin;
  logic         add_start;
  logic [W-1:0] add_sum;
  logic         add_done;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         busy;

  always #5 clock = ~clock;

  serial_add_sequencer #(.BIT_WIDTH(W), .FIFO_DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_ain   (add_ain),
    .add_bin   (add_bin),
    .add_start (add_start),
    .add_sum   (add_sum),
    .add_done  (add_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  // Serial adder stand-in: done rises LAT cycles after start, held until start drops.
  logic         model_done;
  logic [W-1:0] model_sum;
  int           model_cnt;
  logic         stale_done;

  assign add_done = model_done | stale_done;
  assign add_sum  = model_sum;

  always @(posedge clock) begin
    if (reset) begin
      model_done <= 1'b0;
      model_sum  <= '0;
      model_cnt  <= 0;
    end else if (!add_start) begin
      model_done <= 1'b0;
      model_cnt  <= 0;
    end else if (!model_done) begin
      if (model_cnt == LAT-1) begin
        model_done <= 1'b1;
        model_sum  <= add_ain + add_bin;
        model_cnt  <= 0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
  } res_t;
  res_t results[$];

  int   start_rises = 0;
  logic start_q = 1'b0;
  logic saw_full = 1'b0;

  always @(negedge clock) begin
    start_q <= add_start;
    if (add_start && !start_q) start_rises <= start_rises + 1;
    if (!reset && !in_ready) saw_full <= 1'b1;
    if (!reset && out_valid && out_ready) results.push_back('{out_sum, out_carry});
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 after the pair was accepted.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    forever begin
      @(negedge clock);
      if (in_ready || cyc >= 500) break;
      cyc++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL push_timeout: in_ready got 0 expected 1");
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input string name);
    int cyc = 0;
    while (results.size() < n && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    if (results.size() < n) begin
      n_total++;
      $display("FAIL %s_timeout: results got %0d expected %0d", name, results.size(), n);
    end
  endtask

  function automatic logic [W-1:0] res_sum(input int idx);
    return (idx < results.size()) ? results[idx].sum : 'x;
  endfunction

  function automatic logic res_carry(input int idx);
    return (idx < results.size()) ? results[idx].carry : 1'bx;
  endfunction

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int base;
    int rises0;
    int errs;
    logic [W-1:0] held;

    vecs[0] = '{8'h25, 8'h1A, 8'h3F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h80, 8'hFF, 1'b0};
    vecs[4] = '{8'hFE, 8'hFF, 8'hFD, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; stale_done = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_add_start", add_start, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_add_ain", {add_ain, add_bin}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Stale done while idle must be ignored.
    stale_done = 1'b1;
    repeat (2) @(negedge clock);
    check("stale_out_valid", out_valid, 0);
    check("stale_busy", busy, 0);
    @(posedge clock); #1;
    stale_done = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("stale_no_result", results.size(), 0);

    // Single pairs from the vector table.
    for (int i = 0; i < 6; i++) begin
      base   = results.size();
      rises0 = start_rises;
      push(vecs[i].a, vecs[i].b);
      wait_results(base + 1, "vec");
      repeat (3) @(negedge clock);
      check($sformatf("vec%0d_sum", i), res_sum(base), vecs[i].sum);
      check($sformatf("vec%0d_carry", i), res_carry(base), vecs[i].carry & CARRY_ON);
      check($sformatf("vec%0d_start_pulses", i), start_rises - rises0, 1);
      @(posedge clock); #1;
    end

    // Back-to-back pushes fill the queue; results come out in order.
    saw_full = 1'b0;
    base = results.size();
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    wait_results(base + 4, "b2b");
    check("b2b_in_ready_dropped", saw_full, 1);
    check("b2b_sum0", res_sum(base),     8'd3);
    check("b2b_sum1", res_sum(base + 1), 8'd7);
    check("b2b_sum2", res_sum(base + 2), 8'd11);
    check("b2b_sum3", res_sum(base + 3), 8'd15);
    @(posedge clock); #1;

    // Backpressure: result held, nothing issued, queued pairs wait.
    out_ready = 1'b0;
    base = results.size();
    push(8'd10, 8'd20);
    push(8'd30, 8'd40);
    push(8'd50, 8'd60);
    begin
      int cyc = 0;
      while (!out_valid && cyc < 500) begin
        @(negedge clock);
        cyc++;
      end
    end
    check("bp_out_valid", out_valid, 1);
    rises0 = start_rises;
    held   = out_sum;
    check("bp_first_sum", held, 8'd30);
    errs = 0;
    repeat (30) begin
      @(negedge clock);
      if (out_sum !== held || add_start !== 1'b0 || out_valid !== 1'b1) errs++;
    end
    check("bp_stable", errs, 0);
    check("bp_no_start", start_rises - rises0, 0);
    check("bp_busy", busy, 0);
    check("bp_in_ready", in_ready, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_results(base + 3, "bp");
    check("bp_sum0", res_sum(base),     8'd30);
    check("bp_sum1", res_sum(base + 1), 8'd70);
    check("bp_sum2", res_sum(base + 2), 8'd110);
    @(posedge clock); #1;

    // Reset during ISSUE abandons the pair.
    base = results.size();
    push(8'd9, 8'd9);
    begin
      int cyc = 0;
      while (!add_start && cyc < 100) begin
        @(negedge clock);
        cyc++;
      end
    end
    check("mid_in_issue", add_start, 1);
    check("mid_ain", {add_ain, add_bin}, {8'd9, 8'd9});
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_add_start", add_start, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_busy", busy, 0);
    repeat (30) @(negedge clock);
    check("mid_no_result", results.size() - base, 0);
    @(posedge clock); #1;

    // Recovery after the mid-operation reset.
    push(8'd2, 8'd3);
    wait_results(base + 1, "rec");
    check("rec_sum", res_sum(base), 8'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1);
  end

endmodule
